// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, shift schedule, FSM encoding, rotate helper.
// Table entries use DES 1-indexed bit numbering where bit 1 is the MSB.
package des_pkg;

  localparam int ROUND_W = 5;
  localparam int HALF_W  = 28;
  localparam int CD_W    = 56;
  localparam int SK_W    = 48;
  localparam int KEY_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [SK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Shift amount for 1-based round r; rounds outside 1..16 rotate by zero.
  function automatic logic [1:0] shift_amt(input int r);
    logic [1:0] a;
    logic [3:0] idx;
    a   = 2'd0;
    idx = 4'(r - 1);
    if (r >= 1 && r <= 16) a = 2'(SHIFT_TBL[idx]);
    return a;
  endfunction

  // Rotating "left" moves bits toward DES bit 1, i.e. toward the vector MSB.
  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input logic [1:0]        amt,
                                              input logic              right);
    logic [HALF_W-1:0] y;
    y = x;
    if (right) begin
      if (amt == 2'd1)      y = {x[0], x[27:1]};
      else if (amt == 2'd2) y = {x[1:0], x[27:2]};
    end else begin
      if (amt == 2'd1)      y = {x[26:0], x[27]};
      else if (amt == 2'd2) y = {x[25:0], x[27:26]};
    end
    return y;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure wiring that selects 48 of the 56 C/D bits to form a round subkey.
// Both ports use [N:1] vectors so DES bit n sits at index N+1-n.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W:1] i_cd,
  output logic [SK_W:1] o_subkey
);

  for (genvar j = 1; j <= SK_W; j++) begin : g_sel
    assign o_subkey[SK_W+1-j] = i_cd[CD_W+1-PC2_TBL[j-1]];
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// DES round sequencer: PC-1 load on start, per-round C/D rotation, registered PC-2 subkey, start/busy/done.
// Define DES_KEY_PARITY_CHECK_EN to add key_err and reject keys whose bytes fail odd parity.
module des_key_sched_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic [KEY_W:1]     key,
  input  logic               hold,
  output logic               busy,
  output logic               round_en,
  output logic [ROUND_W:1]   round_num,
  output logic [SK_W:1]      subkey,
  output logic               last_round,
  output logic               done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic               key_err
`endif
);

  localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS);

  state_t             r_state;
  logic [CD_W:1]      r_cd;
  logic               r_dec;
  logic [ROUND_W-1:0] r_round;
  logic [SK_W:1]      r_subkey;
  logic               r_busy;
  logic               r_done;

  logic [CD_W:1]      w_pc1;
  logic [CD_W:1]      w_src;
  logic [CD_W:1]      w_cd_nxt;
  logic [SK_W:1]      w_subkey_nxt;
  logic               w_dec_sel;
  logic [ROUND_W-1:0] w_next_round;
  logic [1:0]         w_amt;
  logic               w_key_ok;
  logic               w_accept;
  logic               w_idle;

  for (genvar i = 1; i <= CD_W; i++) begin : g_pc1
    assign w_pc1[CD_W+1-i] = key[KEY_W+1-PC1_TBL[i-1]];
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] w_par_ok;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign w_par_ok[b] = ^key[8*b+8 : 8*b+1];
  end
  assign w_key_ok = &w_par_ok;
`else
  logic w_unused_par;
  assign w_unused_par = ^{key[57], key[49], key[41], key[33], key[25], key[17], key[9], key[1]};
  assign w_key_ok     = 1'b1;
`endif

  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = w_idle && start && w_key_ok;
  assign w_src        = w_idle ? w_pc1 : r_cd;
  assign w_dec_sel    = w_idle ? decrypt : r_dec;
  assign w_next_round = w_idle ? ROUND_W'(1) : r_round + ROUND_W'(1);

  // Decrypt walks the schedule backwards: round 1 is C16/D16 == C0/D0, so no rotation.
  always_comb begin
    w_amt = 2'd0;
    if (w_dec_sel) begin
      if (w_next_round != ROUND_W'(1)) w_amt = shift_amt(18 - int'(w_next_round));
    end else begin
      w_amt = shift_amt(int'(w_next_round));
    end
  end

  assign w_cd_nxt = {rot28(w_src[CD_W:HALF_W+1], w_amt, w_dec_sel),
                     rot28(w_src[HALF_W:1],      w_amt, w_dec_sel)};

  des_pc2 u_pc2 (
    .i_cd     (w_cd_nxt),
    .o_subkey (w_subkey_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cd     <= '0;
      r_dec    <= 1'b0;
      r_round  <= '0;
      r_subkey <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_ROUND;
            r_cd     <= w_cd_nxt;
            r_subkey <= w_subkey_nxt;
            r_dec    <= decrypt;
            r_round  <= ROUND_W'(1);
            r_busy   <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (!hold) begin
            if (r_round == LAST_RND) begin
              r_state <= ST_DONE;
              r_round <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_round  <= w_next_round;
              r_cd     <= w_cd_nxt;
              r_subkey <= w_subkey_nxt;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic r_key_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_key_err <= 1'b0;
    else     r_key_err <= w_idle && start && !w_key_ok;
  end
  assign key_err = r_key_err;
`endif

  // Hold gates round_en in the same cycle, so these two stay combinational.
  assign round_en   = (r_state == ST_ROUND) && !hold;
  assign last_round = round_en && (r_round == LAST_RND);
  assign busy       = r_busy;
  assign round_num  = r_round;
  assign subkey     = r_subkey;
  assign done       = r_done;

endmodule
